// File: rtl/exception_commit.sv
// exception_commit: MEM-stage arbiter that picks the first exception/ERET of a dual-issue pair and
// produces the CP0 record, slot kill masks and a multi-cycle flush. Optional macro: TRAP_EXC_EN.
module exception_commit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_EPC    = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        s0_valid,
  input  logic [31:0] s0_pc,
  input  logic        s0_in_ds,
  input  logic [7:0]  s0_exc,
  input  logic [31:0] s0_badvaddr,
  input  logic        s0_eret,
  input  logic        s1_valid,
  input  logic [31:0] s1_pc,
  input  logic        s1_in_ds,
  input  logic [7:0]  s1_exc,
  input  logic [31:0] s1_badvaddr,
  input  logic        s1_eret,
  input  logic        int_pending,
  output logic        in_ready,
  output logic        kill_s0,
  output logic        kill_s1,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        exc_badv_we,
  output logic        eret_valid,
  output logic        flush
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
`ifdef TRAP_EXC_EN
  localparam logic [7:0] EXC_MASK = 8'hFF;
`else
  localparam logic [7:0] EXC_MASK = 8'hFB;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // flag vector is {adel_if, ri, sys, bp, ov, tr, adel_d, ades_d}
  function automatic logic [4:0] code_of(input logic intr, input logic [7:0] f);
    logic [4:0] c;
    c = 5'h00;
    if (!intr) begin
      if      (f[7]) c = 5'h04;
      else if (f[6]) c = 5'h0A;
      else if (f[5]) c = 5'h08;
      else if (f[4]) c = 5'h09;
      else if (f[3]) c = 5'h0C;
      else if (f[2]) c = 5'h0D;
      else if (f[1]) c = 5'h04;
      else if (f[0]) c = 5'h05;
    end
    return c;
  endfunction

  function automatic logic badv_of(input logic intr, input logic [7:0] f);
    return !intr && (f[7] || (f[6:2] == 5'd0 && (f[1] || f[0])));
  endfunction

  logic [7:0]  s0_f, s1_f, sel_f;
  logic        int0, exc0, exc1, ev0, ev1;
  logic        sel_int, sel_exc, sel_ds;
  logic [31:0] sel_pc, sel_badvaddr;
  logic        accept, take;

  assign s0_f = s0_valid ? (s0_exc & EXC_MASK) : 8'h00;
  assign s1_f = s1_valid ? (s1_exc & EXC_MASK) : 8'h00;
  assign int0 = s0_valid & int_pending;
  assign exc0 = int0 | (|s0_f);
  assign exc1 = |s1_f;
  assign ev0  = exc0 | (s0_valid & s0_eret);
  assign ev1  = exc1 | (s1_valid & s1_eret);

  // slot 0 event wins; otherwise slot 1 fields are presented
  always_comb begin
    sel_int      = 1'b0;
    sel_f        = s1_f;
    sel_exc      = exc1;
    sel_ds       = s1_in_ds;
    sel_pc       = s1_pc;
    sel_badvaddr = s1_badvaddr;
    if (ev0) begin
      sel_int      = int0;
      sel_f        = s0_f;
      sel_exc      = exc0;
      sel_ds       = s0_in_ds;
      sel_pc       = s0_pc;
      sel_badvaddr = s0_badvaddr;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // acceptance and kill masks
  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_ready & ~stall;
    take     = accept & (ev0 | ev1);
    kill_s0  = accept & ev0;
    kill_s1  = accept & (ev0 | ev1);
  end

  // CP0 record and flush, registered one cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_valid    <= 1'b0;
      eret_valid   <= 1'b0;
      flush        <= 1'b0;
      exc_code     <= 5'h00;
      exc_epc      <= RESET_EPC;
      exc_bd       <= 1'b0;
      exc_badvaddr <= 32'h0;
      exc_badv_we  <= 1'b0;
    end else begin
      exc_valid   <= take & sel_exc;
      eret_valid  <= take & ~sel_exc;
      exc_badv_we <= take & sel_exc & badv_of(sel_int, sel_f);
      flush       <= (state_d == FLUSH);
      if (take && sel_exc) begin
        exc_code <= code_of(sel_int, sel_f);
        exc_epc  <= sel_ds ? (sel_pc - 32'd4) : sel_pc;
        exc_bd   <= sel_ds;
        if (badv_of(sel_int, sel_f))
          exc_badvaddr <= sel_f[7] ? sel_pc : sel_badvaddr;
      end
    end
  end

endmodule

// File: tb/tb_exception_commit.sv
// Bench for exception_commit: directed vector table, multi-cycle sequences and a randomized run
// against a priority-list reference model.
module tb_exception_commit;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_EPC = 32'hBFC0_0000;
`ifdef TRAP_EXC_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk, rst, stall, int_pending;
  logic        s0_valid, s0_in_ds, s0_eret, s1_valid, s1_in_ds, s1_eret;
  logic [31:0] s0_pc, s0_badvaddr, s1_pc, s1_badvaddr;
  logic [7:0]  s0_exc, s1_exc;
  logic        in_ready, kill_s0, kill_s1, exc_valid, exc_bd, exc_badv_we, eret_valid, flush;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exception_commit #(.FLUSH_CYCLES(FLUSH_CYCLES), .RESET_EPC(RESET_EPC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_in_ds(s0_in_ds), .s0_exc(s0_exc),
    .s0_badvaddr(s0_badvaddr), .s0_eret(s0_eret),
    .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_in_ds(s1_in_ds), .s1_exc(s1_exc),
    .s1_badvaddr(s1_badvaddr), .s1_eret(s1_eret),
    .int_pending(int_pending), .in_ready(in_ready), .kill_s0(kill_s0), .kill_s1(kill_s1),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .exc_badv_we(exc_badv_we), .eret_valid(eret_valid),
    .flush(flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; int_pending = 0;
    s0_valid = 0; s0_pc = 0; s0_in_ds = 0; s0_exc = 0; s0_badvaddr = 0; s0_eret = 0;
    s1_valid = 0; s1_pc = 0; s1_in_ds = 0; s1_exc = 0; s1_badvaddr = 0; s1_eret = 0;
  endtask

  // called at a negedge; returns at posedge+1 with the block idle
  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    logic        s0v; logic [31:0] s0pc; logic s0ds; logic [7:0] s0x; logic [31:0] s0b; logic s0e;
    logic        s1v; logic [31:0] s1pc; logic s1ds; logic [7:0] s1x; logic [31:0] s1b; logic s1e;
    logic        intp;
    logic        k0, k1, ev, er;
    logic [4:0]  code; logic [31:0] epc; logic bd, bwe; logic [31:0] bva;
  } vec_t;

  function automatic vec_t mk(
      input string n,
      input logic a0v, input logic [31:0] a0pc, input logic a0ds, input logic [7:0] a0x,
      input logic [31:0] a0b, input logic a0e,
      input logic a1v, input logic [31:0] a1pc, input logic a1ds, input logic [7:0] a1x,
      input logic [31:0] a1b, input logic a1e, input logic ip,
      input logic k0, input logic k1, input logic ev, input logic er,
      input logic [4:0] code, input logic [31:0] epc, input logic bd, input logic bwe,
      input logic [31:0] bva);
    vec_t v;
    v.name = n;
    v.s0v = a0v; v.s0pc = a0pc; v.s0ds = a0ds; v.s0x = a0x; v.s0b = a0b; v.s0e = a0e;
    v.s1v = a1v; v.s1pc = a1pc; v.s1ds = a1ds; v.s1x = a1x; v.s1b = a1b; v.s1e = a1e;
    v.intp = ip; v.k0 = k0; v.k1 = k1; v.ev = ev; v.er = er;
    v.code = code; v.epc = epc; v.bd = bd; v.bwe = bwe; v.bva = bva;
    return v;
  endfunction

  // reference model: priority list per slot, flush as a remaining-cycles count
  typedef struct packed {
    logic hit; logic slot; logic eret; logic [4:0] code; logic bwe;
    logic [31:0] bva; logic [31:0] epc; logic bd;
  } ev_t;
  localparam logic [4:0] FLAG_CODE [8] = '{5'h04, 5'h0A, 5'h08, 5'h09, 5'h0C, 5'h0D, 5'h04, 5'h05};

  int          m_left;
  logic        m_exc_valid, m_eret_valid, m_flush, m_bd, m_bwe;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva;

  function automatic ev_t pick();
    ev_t e;
    logic v [2]; logic ds [2]; logic er [2];
    logic [31:0] pc [2]; logic [31:0] bv [2]; logic [7:0] x [2];
    e = '0;
    v[0] = s0_valid; ds[0] = s0_in_ds; er[0] = s0_eret; pc[0] = s0_pc; bv[0] = s0_badvaddr; x[0] = s0_exc;
    v[1] = s1_valid; ds[1] = s1_in_ds; er[1] = s1_eret; pc[1] = s1_pc; bv[1] = s1_badvaddr; x[1] = s1_exc;
    for (int s = 0; s < 2; s++) begin
      if (e.hit || !v[s]) continue;
      if (s == 0 && int_pending) begin
        e.hit = 1; e.code = 5'h00;
      end else begin
        for (int p = 0; p < 8; p++) begin
          if (!e.hit && x[s][3'(7 - p)] && !(p == 5 && !TRAP_EN)) begin
            e.hit = 1; e.code = FLAG_CODE[p];
            e.bwe = (p == 0 || p == 6 || p == 7);
            e.bva = (p == 0) ? pc[s] : bv[s];
          end
        end
      end
      if (!e.hit && er[s]) begin e.hit = 1; e.eret = 1; end
      if (e.hit) begin
        e.slot = 1'(s);
        e.epc  = ds[s] ? pc[s] - 32'd4 : pc[s];
        e.bd   = ds[s];
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_left = 0; m_exc_valid = 0; m_eret_valid = 0; m_flush = 0; m_bd = 0; m_bwe = 0;
    m_code = 5'h00; m_epc = RESET_EPC; m_bva = 32'h0;
  endtask

  task automatic model_step(input ev_t e, input logic acc);
    m_exc_valid = 0; m_eret_valid = 0; m_bwe = 0;
    if (m_left > 0) begin
      m_left--;
      m_flush = (m_left > 0);
    end else if (acc && e.hit) begin
      m_left = FLUSH_CYCLES;
      m_flush = 1;
      if (e.eret) m_eret_valid = 1;
      else begin
        m_exc_valid = 1; m_code = e.code; m_epc = e.epc; m_bd = e.bd; m_bwe = e.bwe;
        if (e.bwe) m_bva = e.bva;
      end
    end else begin
      m_flush = 0;
    end
  endtask

  task automatic rand_inputs();
    stall = ($urandom_range(0, 3) == 0);
    int_pending = ($urandom_range(0, 7) == 0);
    s0_valid = ($urandom_range(0, 3) != 0);
    s1_valid = ($urandom_range(0, 3) != 0);
    s0_pc = $urandom() & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
    s1_pc = s0_pc + 32'd4;
    s0_in_ds = 1'($urandom_range(0, 1));
    s1_in_ds = 1'($urandom_range(0, 1));
    s0_badvaddr = $urandom(); s1_badvaddr = $urandom();
    s0_exc = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
    s1_exc = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
    s0_eret = ($urandom_range(0, 9) == 0);
    s1_eret = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  vec_t vecs [11];
  ev_t  e;
  logic acc;
  int   nflush;

  initial begin
    clear_inputs();
    rst = 1;
    vecs[0] = TRAP_EN ?
      mk("s1_trap", 1, 32'h8000_0100, 0, 8'h00, 0, 0, 1, 32'h8000_0104, 0, 8'h04, 0, 0, 0,
         0, 1, 1, 0, 5'h0D, 32'h8000_0104, 0, 0, 0) :
      mk("s1_trap", 1, 32'h8000_0100, 0, 8'h00, 0, 0, 1, 32'h8000_0104, 0, 8'h04, 0, 0, 0,
         0, 0, 0, 0, 5'h00, 0, 0, 0, 0);
    vecs[1] = mk("s0_ds_ov", 1, 32'h8000_0200, 1, 8'h08, 0, 0, 1, 32'h8000_0204, 0, 8'h00, 0, 0, 0,
                 1, 1, 1, 0, 5'h0C, 32'h8000_01FC, 1, 0, 0);
    vecs[2] = mk("s0_adel_if_ri", 1, 32'h0000_0003, 0, 8'hC0, 32'hDEAD_0000, 0, 0, 0, 0, 8'h00, 0, 0, 0,
                 1, 1, 1, 0, 5'h04, 32'h0000_0003, 0, 1, 32'h0000_0003);
    vecs[3] = mk("s1_ades_ds", 1, 32'h8000_0300, 0, 8'h00, 0, 0, 1, 32'h8000_0304, 1, 8'h01, 32'h1234_5679, 0, 0,
                 0, 1, 1, 0, 5'h05, 32'h8000_0300, 1, 1, 32'h1234_5679);
    vecs[4] = mk("s0_invalid", 0, 32'h8000_0400, 0, 8'h20, 0, 0, 1, 32'h8000_0404, 0, 8'h20, 0, 0, 0,
                 0, 1, 1, 0, 5'h08, 32'h8000_0404, 0, 0, 0);
    vecs[5] = mk("s0_eret", 1, 32'h8000_0500, 0, 8'h00, 0, 1, 1, 32'h8000_0504, 0, 8'h00, 0, 0, 0,
                 1, 1, 0, 1, 5'h00, 0, 0, 0, 0);
    vecs[6] = mk("s1_eret", 1, 32'h8000_0508, 0, 8'h00, 0, 0, 1, 32'h8000_050C, 0, 8'h00, 0, 1, 0,
                 0, 1, 0, 1, 5'h00, 0, 0, 0, 0);
    vecs[7] = mk("s0_bp_s1_ri", 1, 32'h8000_0600, 0, 8'h10, 0, 0, 1, 32'h8000_0604, 0, 8'h40, 0, 0, 0,
                 1, 1, 1, 0, 5'h09, 32'h8000_0600, 0, 0, 0);
    vecs[8] = mk("int_over_sys", 1, 32'h8000_0700, 0, 8'h20, 0, 0, 1, 32'h8000_0704, 0, 8'h00, 0, 0, 1,
                 1, 1, 1, 0, 5'h00, 32'h8000_0700, 0, 0, 0);
    vecs[9] = mk("adel_d_eret", 1, 32'h8000_0800, 0, 8'h02, 32'h0000_0801, 1, 0, 0, 0, 8'h00, 0, 0, 0,
                 1, 1, 1, 0, 5'h04, 32'h8000_0800, 0, 1, 32'h0000_0801);
    vecs[10] = mk("quiet", 1, 32'h8000_0900, 0, 8'h00, 0, 0, 1, 32'h8000_0904, 0, 8'h00, 0, 0, 0,
                  0, 0, 0, 0, 5'h00, 0, 0, 0, 0);

    // reset state
    @(negedge clk);
    chk("rst_exc_valid", exc_valid, 0);   chk("rst_eret_valid", eret_valid, 0);
    chk("rst_flush", flush, 0);           chk("rst_exc_bd", exc_bd, 0);
    chk("rst_badv_we", exc_badv_we, 0);   chk("rst_exc_code", exc_code, 0);
    chk("rst_badvaddr", exc_badvaddr, 0); chk("rst_exc_epc", exc_epc, RESET_EPC);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 0;

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      s0_valid = vecs[i].s0v; s0_pc = vecs[i].s0pc; s0_in_ds = vecs[i].s0ds; s0_exc = vecs[i].s0x;
      s0_badvaddr = vecs[i].s0b; s0_eret = vecs[i].s0e;
      s1_valid = vecs[i].s1v; s1_pc = vecs[i].s1pc; s1_in_ds = vecs[i].s1ds; s1_exc = vecs[i].s1x;
      s1_badvaddr = vecs[i].s1b; s1_eret = vecs[i].s1e; int_pending = vecs[i].intp;
      @(negedge clk);
      chk({vecs[i].name, ".in_ready"}, in_ready, 1);
      chk({vecs[i].name, ".kill_s0"}, kill_s0, vecs[i].k0);
      chk({vecs[i].name, ".kill_s1"}, kill_s1, vecs[i].k1);
      @(posedge clk); #1 clear_inputs();
      @(negedge clk);
      chk({vecs[i].name, ".exc_valid"}, exc_valid, vecs[i].ev);
      chk({vecs[i].name, ".eret_valid"}, eret_valid, vecs[i].er);
      chk({vecs[i].name, ".flush"}, flush, vecs[i].ev | vecs[i].er);
      chk({vecs[i].name, ".badv_we"}, exc_badv_we, vecs[i].bwe);
      if (vecs[i].ev) begin
        chk({vecs[i].name, ".exc_code"}, exc_code, vecs[i].code);
        chk({vecs[i].name, ".exc_epc"}, exc_epc, vecs[i].epc);
        chk({vecs[i].name, ".exc_bd"}, exc_bd, vecs[i].bd);
        if (vecs[i].bwe) chk({vecs[i].name, ".badvaddr"}, exc_badvaddr, vecs[i].bva);
      end
      wait_idle();
    end

    // interrupt waits for a valid slot 0
    int_pending = 1; s1_valid = 1; s1_pc = 32'h8000_0A04;
    @(negedge clk);
    chk("int_bubble.kill_s0", kill_s0, 0); chk("int_bubble.kill_s1", kill_s1, 0);
    @(posedge clk); #1 s0_valid = 1; s0_pc = 32'h8000_0A00;
    @(negedge clk);
    chk("int_bubble.no_exc", exc_valid, 0);
    chk("int_take.kill_s0", kill_s0, 1); chk("int_take.kill_s1", kill_s1, 1);
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    chk("int_take.exc_valid", exc_valid, 1); chk("int_take.exc_code", exc_code, 5'h00);
    chk("int_take.exc_epc", exc_epc, 32'h8000_0A00); chk("int_take.badv_we", exc_badv_we, 0);
    wait_idle();

    // stall for three cycles, then accept; a second sys during flush (with stall) is ignored
    stall = 1; s0_valid = 1; s0_pc = 32'h8000_0B00; s0_exc = 8'h20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall.kill_s0", kill_s0, 0); chk("stall.kill_s1", kill_s1, 0);
      chk("stall.exc_valid", exc_valid, 0); chk("stall.in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    stall = 0;
    @(negedge clk);
    chk("unstall.kill_s0", kill_s0, 1);
    @(posedge clk); #1 s0_pc = 32'h8000_0C00; s1_valid = 1; s1_exc = 8'h20;
    @(negedge clk);
    chk("flush1.exc_valid", exc_valid, 1); chk("flush1.exc_code", exc_code, 5'h08);
    chk("flush1.exc_epc", exc_epc, 32'h8000_0B00); chk("flush1.flush", flush, 1);
    chk("flush1.in_ready", in_ready, 0); chk("flush1.kill_s0", kill_s0, 0); chk("flush1.kill_s1", kill_s1, 0);
    @(posedge clk); #1 stall = 1;
    @(negedge clk);
    chk("flush2.exc_valid", exc_valid, 0); chk("flush2.flush", flush, 1); chk("flush2.kill_s1", kill_s1, 0);
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    chk("flush_end.flush", flush, 0); chk("flush_end.in_ready", in_ready, 1);
    chk("flush_end.exc_valid", exc_valid, 0); chk("flush_end.exc_epc", exc_epc, 32'h8000_0B00);
    @(posedge clk); #1;

    // flush width measured for a plain exception
    s0_valid = 1; s0_pc = 32'h8000_0D00; s0_exc = 8'h08;
    @(posedge clk); #1 clear_inputs();
    nflush = 0;
    @(negedge clk);
    while (flush && nflush < 20) begin nflush++; @(negedge clk); end
    chk("flush_width", nflush, FLUSH_CYCLES);
    wait_idle();

    // reset mid-flush, then ERET
    s0_valid = 1; s0_pc = 32'h8000_0E00; s0_exc = 8'h08;
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    chk("pre_rst.flush", flush, 1); chk("pre_rst.exc_epc", exc_epc, 32'h8000_0E00);
    #1 rst = 1;
    #1;
    chk("mid_rst.flush", flush, 0); chk("mid_rst.exc_epc", exc_epc, RESET_EPC);
    chk("mid_rst.exc_code", exc_code, 0); chk("mid_rst.in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 0;
    s0_valid = 1; s0_pc = 32'h8000_0F00; s0_eret = 1;
    @(negedge clk);
    chk("eret.kill_s0", kill_s0, 1); chk("eret.kill_s1", kill_s1, 1);
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    chk("eret.eret_valid", eret_valid, 1); chk("eret.exc_valid", exc_valid, 0);
    chk("eret.exc_epc", exc_epc, RESET_EPC); chk("eret.flush", flush, 1);
    wait_idle();

    // randomized run against the reference model
    rst = 1;
    @(posedge clk); #1 rst = 0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin stall = 1; model_reset(); end
      e = pick();
      acc = (m_left == 0) && !stall && !rst;
      @(negedge clk);
      chk("r.in_ready", in_ready, m_left == 0);
      chk("r.kill_s0", kill_s0, acc && e.hit && !e.slot);
      chk("r.kill_s1", kill_s1, acc && e.hit);
      chk("r.exc_valid", exc_valid, m_exc_valid);
      chk("r.eret_valid", eret_valid, m_eret_valid);
      chk("r.flush", flush, m_flush);
      chk("r.exc_code", exc_code, m_code);
      chk("r.exc_epc", exc_epc, m_epc);
      chk("r.exc_bd", exc_bd, m_bd);
      chk("r.badv_we", exc_badv_we, m_bwe);
      chk("r.badvaddr", exc_badvaddr, m_bva);
      @(posedge clk);
      if (!rst) model_step(e, acc);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
